// File: rtl/mem_resp_pkg.sv
// Shared types and sizing for the memory responder.
// MEM_CLEAR_ON_RESET_EN adds the CLEAR state used by the post-reset zeroing sweep.
package mem_resp_pkg;

  localparam int ADDR_W_DEF  = 5;
  localparam int DATA_W_DEF  = 16;
  localparam int MAX_LATENCY = 8;
  // One spare bit so the counter can hold MAX_LATENCY itself.
  localparam int CNT_W       = $clog2(MAX_LATENCY) + 1;

`ifdef MEM_CLEAR_ON_RESET_EN
  typedef enum logic [2:0] {
    ST_IDLE, ST_RD_WAIT, ST_WR_ACK, ST_ERR_ACK, ST_CLEAR
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE, ST_RD_WAIT, ST_WR_ACK, ST_ERR_ACK
  } state_t;
`endif

endpackage

// File: rtl/mem_responder_if.sv
// Initiator <-> memory responder bus.
interface mem_responder_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
);
  // Handshake: a request (ReadEnable or WriteEnable) is accepted only on a rising
  // edge where Busy is low; while Busy is high requests are dropped, not queued.
  // Every accepted request completes with exactly one single-cycle Ack (with Error
  // when both enables were set); DataOut is valid from a read Ack until the next one.
  logic [ADDR_W-1:0] Address;
  logic [DATA_W-1:0] DataIN;
  logic              ReadEnable;
  logic              WriteEnable;
  logic [DATA_W-1:0] DataOut;
  logic              Ack;
  logic              Busy;
  logic              Error;

  modport master (
    output Address, DataIN, ReadEnable, WriteEnable,
    input  DataOut, Ack, Busy, Error
  );

  modport slave (
    input  Address, DataIN, ReadEnable, WriteEnable,
    output DataOut, Ack, Busy, Error
  );
endinterface

// File: rtl/mem_resp_array.sv
// Word storage: one synchronous write port, one asynchronous read port, no reset.
module mem_resp_array #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mem_responder.sv
// Memory responder: FSM, read-latency counter, address latch and output registers.
// Define MEM_CLEAR_ON_RESET_EN to zero the whole array after every reset release.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int READ_LATENCY = 1
) (
  input  logic            Clock,
  input  logic            Reset,
  mem_responder_if.slave  bus,
  output state_t          dbg_state_o
);

  localparam logic [CNT_W-1:0] LAT = CNT_W'(READ_LATENCY);

`ifdef MEM_CLEAR_ON_RESET_EN
  localparam state_t RESET_STATE = ST_CLEAR;
`else
  localparam state_t RESET_STATE = ST_IDLE;
`endif

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] dout_q;
  logic              ack_q;
  logic              err_q;
`ifdef MEM_CLEAR_ON_RESET_EN
  logic [ADDR_W-1:0] clr_q;
`endif

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Storage is frozen while Reset is held so contents survive a reset untouched.
  always_comb begin
    mem_we    = Reset && (state_q == ST_IDLE) && bus.WriteEnable && !bus.ReadEnable;
    mem_waddr = bus.Address;
    mem_wdata = bus.DataIN;
`ifdef MEM_CLEAR_ON_RESET_EN
    if (state_q == ST_CLEAR) begin
      mem_we    = Reset;
      mem_waddr = clr_q;
      mem_wdata = '0;
    end
`endif
  end

  mem_resp_array #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_array (
    .clk_i   (Clock),
    .we_i    (mem_we),
    .waddr_i (mem_waddr),
    .wdata_i (mem_wdata),
    .raddr_i (addr_q),
    .rdata_o (mem_rdata)
  );

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= RESET_STATE;
      cnt_q   <= '0;
      addr_q  <= '0;
      dout_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
`ifdef MEM_CLEAR_ON_RESET_EN
      clr_q   <= '0;
`endif
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          case ({bus.ReadEnable, bus.WriteEnable})
            2'b10: begin
              addr_q  <= bus.Address;
              cnt_q   <= CNT_W'(1);
              state_q <= ST_RD_WAIT;
            end
            2'b01: begin
              ack_q   <= 1'b1;
              state_q <= ST_WR_ACK;
            end
            2'b11: begin
              ack_q   <= 1'b1;
              err_q   <= 1'b1;
              state_q <= ST_ERR_ACK;
            end
            default: ;
          endcase
        end
        ST_RD_WAIT: begin
          if (cnt_q == LAT) begin
            dout_q  <= mem_rdata;
            ack_q   <= 1'b1;
            cnt_q   <= '0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_WR_ACK, ST_ERR_ACK: state_q <= ST_IDLE;
`ifdef MEM_CLEAR_ON_RESET_EN
        ST_CLEAR: begin
          clr_q <= clr_q + ADDR_W'(1);
          if (clr_q == '1) state_q <= ST_IDLE;
        end
`endif
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.DataOut  = dout_q;
  assign bus.Ack      = ack_q;
  assign bus.Error    = err_q;
  assign bus.Busy     = (state_q != ST_IDLE);
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance at read latency 1, one at latency 4.
// Build with MEM_CLEAR_ON_RESET_EN to exercise the post-reset clear sweep.
module tb_mem_responder;
  import mem_resp_pkg::*;

`ifdef MEM_CLEAR_ON_RESET_EN
  localparam logic RST_BUSY = 1'b1;
`else
  localparam logic RST_BUSY = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic Clock = 1'b0;
  logic Reset = 1'b0;
  always #5 Clock = ~Clock;

  // ---------------- DUTs ----------------
  mem_responder_if #(.ADDR_W(5), .DATA_W(16)) bus_a ();
  mem_responder_if #(.ADDR_W(5), .DATA_W(16)) bus_b ();
  state_t st_a, st_b;

  mem_responder #(.ADDR_W(5), .DATA_W(16), .READ_LATENCY(1)) dut_a (
    .Clock(Clock), .Reset(Reset), .bus(bus_a.slave), .dbg_state_o(st_a));
  mem_responder #(.ADDR_W(5), .DATA_W(16), .READ_LATENCY(4)) dut_b (
    .Clock(Clock), .Reset(Reset), .bus(bus_b.slave), .dbg_state_o(st_b));

  logic [4:0]  addr;
  logic [15:0] din;
  logic        re, we;
  logic        sel;

  assign bus_a.Address     = addr;
  assign bus_a.DataIN      = din;
  assign bus_a.ReadEnable  = re & ~sel;
  assign bus_a.WriteEnable = we & ~sel;
  assign bus_b.Address     = addr;
  assign bus_b.DataIN      = din;
  assign bus_b.ReadEnable  = re & sel;
  assign bus_b.WriteEnable = we & sel;

  logic        obs_ack, obs_err, obs_busy;
  logic [15:0] obs_dout;
  assign obs_ack  = sel ? bus_b.Ack     : bus_a.Ack;
  assign obs_err  = sel ? bus_b.Error   : bus_a.Error;
  assign obs_busy = sel ? bus_b.Busy    : bus_a.Busy;
  assign obs_dout = sel ? bus_b.DataOut : bus_a.DataOut;

  // ---------------- scoreboard / model ----------------
  logic [15:0] exp_q[$];
  logic [15:0] mem_m [2][32];
  logic [15:0] exp_dout [2];
  int n_pass  = 0;
  int n_total = 0;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  function automatic int lat_of(input logic s);
    return s ? 4 : 1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_write(input logic s, input logic [4:0] a, input logic [15:0] d);
    sel = s; addr = a; din = d; we = 1'b1;
    step();
    we = 1'b0;
    chk1("wr_ack", obs_ack, 1'b1);
    chk1("wr_busy", obs_busy, 1'b1);
    chk1("wr_err", obs_err, 1'b0);
    chk16("wr_dout_hold", obs_dout, exp_dout[s]);
    step();
    chk1("wr_ack_end", obs_ack, 1'b0);
    chk1("wr_idle", obs_busy, 1'b0);
    mem_m[s][a] = d;
  endtask

  task automatic do_read(input logic s, input logic [4:0] a, input logic intrude);
    logic [15:0] exp;
    int lat;
    lat = lat_of(s);
    sel = s; addr = a; re = 1'b1;
    exp_q.push_back(mem_m[s][a]);
    step();
    re = 1'b0;
    for (int i = 1; i <= lat; i++) begin
      chk1("rd_busy", obs_busy, 1'b1);
      chk1("rd_early_ack", obs_ack, 1'b0);
      if (intrude && i == 2) begin
        addr = 5'd2; din = 16'hBEEF; we = 1'b1;
      end else begin
        we = 1'b0; addr = 5'($urandom_range(0, 31));
      end
      step();
    end
    we = 1'b0;
    chk1("rd_ack", obs_ack, 1'b1);
    chk1("rd_busy_end", obs_busy, 1'b0);
    chk1("rd_err", obs_err, 1'b0);
    exp = exp_q.pop_front();
    chk16("rd_data", obs_dout, exp);
    exp_dout[s] = exp;
    step();
    chk1("rd_single_ack", obs_ack, 1'b0);
    chk16("rd_data_hold", obs_dout, exp);
  endtask

  task automatic do_conflict(input logic s, input logic [4:0] a);
    sel = s; addr = a; din = 16'($urandom_range(0, 65535)); re = 1'b1; we = 1'b1;
    step();
    re = 1'b0; we = 1'b0;
    chk1("err_ack", obs_ack, 1'b1);
    chk1("err_flag", obs_err, 1'b1);
    chk1("err_busy", obs_busy, 1'b1);
    chk16("err_dout_hold", obs_dout, exp_dout[s]);
    step();
    chk1("err_ack_end", obs_ack, 1'b0);
    chk1("err_flag_end", obs_err, 1'b0);
  endtask

  // Asserts Reset away from the clock edge and checks the immediate output values.
  task automatic assert_reset();
    #2 Reset = 1'b0;
    #1;
    chk16("rst_dout_a", bus_a.DataOut, 16'h0);
    chk16("rst_dout_b", bus_b.DataOut, 16'h0);
    chk1("rst_ack_a", bus_a.Ack, 1'b0);
    chk1("rst_ack_b", bus_b.Ack, 1'b0);
    chk1("rst_err_a", bus_a.Error, 1'b0);
    chk1("rst_err_b", bus_b.Error, 1'b0);
    chk1("rst_busy_a", bus_a.Busy, RST_BUSY);
    chk1("rst_busy_b", bus_b.Busy, RST_BUSY);
    exp_dout[0] = 16'h0;
    exp_dout[1] = 16'h0;
    @(posedge Clock);
    #1;
  endtask

  task automatic release_reset();
    Reset = 1'b1;
`ifdef MEM_CLEAR_ON_RESET_EN
    for (int i = 0; i < 32; i++) begin
      chk1("clr_busy_a", bus_a.Busy, 1'b1);
      chk1("clr_busy_b", bus_b.Busy, 1'b1);
      chk1("clr_no_ack", bus_a.Ack | bus_b.Ack, 1'b0);
      step();
    end
    for (int s = 0; s < 2; s++)
      for (int a = 0; a < 32; a++) mem_m[s][a] = 16'h0;
`endif
    for (int i = 0; i < 3; i++) begin
      chk1("post_rst_busy_a", bus_a.Busy, 1'b0);
      chk1("post_rst_busy_b", bus_b.Busy, 1'b0);
      chk1("post_rst_no_ack", bus_a.Ack | bus_b.Ack, 1'b0);
      step();
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic        s;
    logic [4:0]  a;
    logic [15:0] d;
    re = 1'b0; we = 1'b0; addr = '0; din = '0; sel = 1'b0;
    exp_dout[0] = 16'h0;
    exp_dout[1] = 16'h0;

    assert_reset();
    step();
    release_reset();

    // Latency 1: write then read, back to back.
    do_write(1'b0, 5'd3, 16'hA5A5);
    do_read(1'b0, 5'd3, 1'b0);
    do_write(1'b0, 5'd10, 16'h0F0F);
    do_read(1'b0, 5'd10, 1'b0);

    // Latency 4, with a write to addr 2 issued while busy.
    do_write(1'b1, 5'd31, 16'h1234);
    do_write(1'b1, 5'd2, 16'h2222);
    do_read(1'b1, 5'd31, 1'b1);
    do_read(1'b1, 5'd2, 1'b0);

    // Read/write conflict leaves storage and DataOut alone.
    do_write(1'b0, 5'd7, 16'h7777);
    do_conflict(1'b0, 5'd7);
    do_read(1'b0, 5'd7, 1'b0);
    do_conflict(1'b1, 5'd31);
    do_read(1'b1, 5'd31, 1'b0);

    for (int i = 0; i < 8; i++) begin
      s = 1'($urandom_range(0, 1));
      a = 5'($urandom_range(0, 31));
      d = 16'($urandom_range(0, 65535));
      do_write(s, a, d);
      do_read(s, a, 1'b0);
    end

    // Reset in the middle of a latency-4 read.
    do_write(1'b1, 5'd9, 16'h5A5A);
    sel = 1'b1; addr = 5'd9; re = 1'b1;
    step();
    re = 1'b0;
    step();
    chk1("mid_read_busy", obs_busy, 1'b1);
    assert_reset();
    release_reset();
    do_read(1'b1, 5'd9, 1'b0);

`ifdef MEM_CLEAR_ON_RESET_EN
    for (int i = 0; i < 32; i++) do_write(1'b0, 5'(i), 16'hFFFF);
    assert_reset();
    release_reset();
    for (int i = 0; i < 32; i++) do_read(1'b0, 5'(i), 1'b0);
`endif

    chk16("queue_empty", 16'(exp_q.size()), 16'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
